// File: rtl/tlm_pkg.sv
// tlm_pkg: types and default constants shared by timing_leak_monitor and its
// seq_mult lanes.
//   state_e      : top-level sequencing states
//   lane_state_e : per-lane multiplier states
//   TLM_WIDTH    : default operand width
//   TLM_TIMEOUT  : default per-lane RUN-cycle budget before abort
package tlm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        REPORT
    } state_e;

    typedef enum logic [1:0] {
        L_IDLE,
        L_RUN,
        L_DONE
    } lane_state_e;

    localparam int TLM_WIDTH   = 4;
    localparam int TLM_TIMEOUT = 16;

endpackage

// File: rtl/timing_leak_monitor_seq_mult.sv
// seq_mult: one sequential shift-add multiplier lane.
// Optional macro: TLM_CONST_TIME_EN (always WIDTH RUN cycles, no early exit).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             load operands, clear accumulator, enter RUN
//   abort             return to L_IDLE immediately (accumulator held)
//   mplier, mcand     operands (WIDTH bits)
//   product           accumulator, 2*WIDTH bits, held until next start
//   done              one-cycle pulse after the final RUN cycle
//   running           high while in RUN
//
// state  | meaning
// L_IDLE | waiting for start
// L_RUN  | one partial product per cycle
// L_DONE | done pulse, back to L_IDLE next cycle
module seq_mult
    import tlm_pkg::*;
#(
    parameter int WIDTH = TLM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mplier,
    input  logic [WIDTH-1:0]     mcand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 running
);

    localparam int IDX_W = $clog2(WIDTH + 1);

    lane_state_e          state_q,  state_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;

    logic [WIDTH-1:0]     mplier_shift;
    logic [IDX_W-1:0]     idx_inc;
    logic [2*WIDTH-1:0]   addend;
    logic                 last_cycle;

    // The multiplicand register is pre-shifted each cycle, so it always holds
    // mcand << idx without a barrel shifter.
    always_comb begin
        mplier_shift = mplier_q >> 1;
        idx_inc      = idx_q + IDX_W'(1);
        addend       = mplier_q[0] ? mcand_q : '0;
`ifdef TLM_CONST_TIME_EN
        last_cycle   = (idx_inc == IDX_W'(WIDTH));
`else
        last_cycle   = (mplier_shift == '0) || (idx_inc == IDX_W'(WIDTH));
`endif
    end

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        if (abort) begin
            state_d = L_IDLE;
        end else if (start && (state_q != L_RUN)) begin
            state_d  = L_RUN;
            mplier_d = mplier;
            mcand_d  = {{WIDTH{1'b0}}, mcand};
            acc_d    = '0;
            idx_d    = '0;
        end else begin
            case (state_q)
                L_RUN: begin
                    acc_d    = acc_q + addend;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shift;
                    idx_d    = idx_inc;
                    if (last_cycle) begin
                        state_d = L_DONE;
                    end
                end
                L_DONE:  state_d = L_IDLE;
                default: state_d = L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= L_IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

    assign product = acc_q;
    assign done    = (state_q == L_DONE);
    assign running = (state_q == L_RUN);

endmodule

// File: rtl/timing_leak_monitor.sv
// timing_leak_monitor: runs two seq_mult lanes from one start, measures each
// lane's RUN-cycle latency and flags latency differences (timing leakage).
// Optional macro: TLM_CONST_TIME_EN (lanes run constant-time, see seq_mult).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    launch both lanes (IDLE only)
//   mplier_a/b, mcand_a/b    lane operands
//   clr_sticky               synchronous clear of leak_sticky (set wins)
//   busy                     lanes running
//   any_done                 either lane's done pulse
//   result_valid             one-cycle pulse in REPORT
//   product_a/b, lat_a/b     per-lane product and RUN-cycle count
//   lat_delta, leak          |lat_a - lat_b| and its non-zero flag
//   leak_sticky, timeout     accumulated leak, last run aborted
//   run_count                completed runs (wraps)
//
// state  | meaning
// IDLE   | waiting for start
// BUSY   | lanes running, counting latency
// REPORT | one cycle, results published
module timing_leak_monitor
    import tlm_pkg::*;
#(
    parameter  int WIDTH   = TLM_WIDTH,
    parameter  int TIMEOUT = TLM_TIMEOUT,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mplier_a,
    input  logic [WIDTH-1:0]     mcand_a,
    input  logic [WIDTH-1:0]     mplier_b,
    input  logic [WIDTH-1:0]     mcand_b,
    input  logic                 clr_sticky,
    output logic                 busy,
    output logic                 any_done,
    output logic                 result_valid,
    output logic [2*WIDTH-1:0]   product_a,
    output logic [2*WIDTH-1:0]   product_b,
    output logic [CNT_W-1:0]     lat_a,
    output logic [CNT_W-1:0]     lat_b,
    output logic [CNT_W-1:0]     lat_delta,
    output logic                 leak,
    output logic                 leak_sticky,
    output logic                 timeout,
    output logic [15:0]          run_count
);

    state_e              state_q,     state_d;
    logic                busy_q,      busy_d;
    logic                valid_q,     valid_d;
    logic [CNT_W-1:0]    lat_a_q,     lat_a_d;
    logic [CNT_W-1:0]    lat_b_q,     lat_b_d;
    logic [CNT_W-1:0]    delta_q,     delta_d;
    logic                leak_q,      leak_d;
    logic                sticky_q,    sticky_d;
    logic                timeout_q,   timeout_d;
    logic [15:0]         run_count_q, run_count_d;
    logic                seen_a_q,    seen_a_d;
    logic                seen_b_q,    seen_b_d;

    logic                lane_start;
    logic                lane_abort;
    logic                done_a, done_b;
    logic                running_a, running_b;
    logic                timeout_hit;
    logic                enter_report;
    logic [CNT_W-1:0]    delta_c;

    seq_mult #(.WIDTH(WIDTH)) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .start   (lane_start),
        .abort   (lane_abort),
        .mplier  (mplier_a),
        .mcand   (mcand_a),
        .product (product_a),
        .done    (done_a),
        .running (running_a)
    );

    seq_mult #(.WIDTH(WIDTH)) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .start   (lane_start),
        .abort   (lane_abort),
        .mplier  (mplier_b),
        .mcand   (mcand_b),
        .product (product_b),
        .done    (done_b),
        .running (running_b)
    );

    always_comb begin
        delta_c = (lat_a_q >= lat_b_q) ? (lat_a_q - lat_b_q) : (lat_b_q - lat_a_q);
        // A lane that has used its whole budget and is still in RUN needs at
        // least one more cycle, so it can never finish in time.
        timeout_hit = (running_a && (lat_a_q == CNT_W'(TIMEOUT))) ||
                      (running_b && (lat_b_q == CNT_W'(TIMEOUT)));
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        valid_d      = 1'b0;
        lat_a_d      = lat_a_q;
        lat_b_d      = lat_b_q;
        delta_d      = delta_q;
        leak_d       = leak_q;
        timeout_d    = timeout_q;
        run_count_d  = run_count_q;
        seen_a_d     = seen_a_q;
        seen_b_d     = seen_b_q;
        sticky_d     = clr_sticky ? 1'b0 : sticky_q;
        lane_start   = 1'b0;
        lane_abort   = 1'b0;
        enter_report = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lane_start = 1'b1;
                    lat_a_d    = '0;
                    lat_b_d    = '0;
                    timeout_d  = 1'b0;
                    seen_a_d   = 1'b0;
                    seen_b_d   = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                seen_a_d = seen_a_q | done_a;
                seen_b_d = seen_b_q | done_b;
                if (timeout_hit) begin
                    lane_abort   = 1'b1;
                    timeout_d    = 1'b1;
                    enter_report = 1'b1;
                end else begin
                    if (running_a) lat_a_d = lat_a_q + CNT_W'(1);
                    if (running_b) lat_b_d = lat_b_q + CNT_W'(1);
                    if (seen_a_d && seen_b_d) begin
                        enter_report = 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Results are registered on entry so they are visible during REPORT;
        // lane counters are frozen at that point (both done, or aborted).
        if (enter_report) begin
            state_d     = REPORT;
            busy_d      = 1'b0;
            valid_d     = 1'b1;
            delta_d     = delta_c;
            leak_d      = (delta_c != '0);
            run_count_d = run_count_q + 16'd1;
            if (delta_c != '0) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            lat_a_q     <= '0;
            lat_b_q     <= '0;
            delta_q     <= '0;
            leak_q      <= 1'b0;
            sticky_q    <= 1'b0;
            timeout_q   <= 1'b0;
            run_count_q <= '0;
            seen_a_q    <= 1'b0;
            seen_b_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            lat_a_q     <= lat_a_d;
            lat_b_q     <= lat_b_d;
            delta_q     <= delta_d;
            leak_q      <= leak_d;
            sticky_q    <= sticky_d;
            timeout_q   <= timeout_d;
            run_count_q <= run_count_d;
            seen_a_q    <= seen_a_d;
            seen_b_q    <= seen_b_d;
        end
    end

    assign busy         = busy_q;
    assign any_done     = done_a | done_b;
    assign result_valid = valid_q;
    assign lat_a        = lat_a_q;
    assign lat_b        = lat_b_q;
    assign lat_delta    = delta_q;
    assign leak         = leak_q;
    assign leak_sticky  = sticky_q;
    assign timeout      = timeout_q;
    assign run_count    = run_count_q;

endmodule

// File: tb/tb_timing_leak_monitor.sv
module tb_timing_leak_monitor;

`ifdef TLM_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_t = 1'b0;
    logic clr_sticky = 1'b0;
    logic [3:0] mplier_a = '0, mcand_a = '0, mplier_b = '0, mcand_b = '0;

    logic busy, any_done, result_valid, leak, leak_sticky, timeout;
    logic [7:0] product_a, product_b;
    logic [4:0] lat_a, lat_b, lat_delta;
    logic [15:0] run_count;

    logic busy_t, any_done_t, result_valid_t, leak_t, leak_sticky_t, timeout_t;
    logic [7:0] product_a_t, product_b_t;
    logic [1:0] lat_a_t, lat_b_t, lat_delta_t;
    logic [15:0] run_count_t;

    int checks = 0;
    int errors = 0;

    timing_leak_monitor #(.WIDTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mplier_a(mplier_a), .mcand_a(mcand_a), .mplier_b(mplier_b), .mcand_b(mcand_b),
        .clr_sticky(clr_sticky), .busy(busy), .any_done(any_done),
        .result_valid(result_valid), .product_a(product_a), .product_b(product_b),
        .lat_a(lat_a), .lat_b(lat_b), .lat_delta(lat_delta), .leak(leak),
        .leak_sticky(leak_sticky), .timeout(timeout), .run_count(run_count)
    );

    timing_leak_monitor #(.WIDTH(4), .TIMEOUT(2)) dut_to (
        .clk(clk), .rst(rst), .start(start_t),
        .mplier_a(mplier_a), .mcand_a(mcand_a), .mplier_b(mplier_b), .mcand_b(mcand_b),
        .clr_sticky(clr_sticky), .busy(busy_t), .any_done(any_done_t),
        .result_valid(result_valid_t), .product_a(product_a_t), .product_b(product_b_t),
        .lat_a(lat_a_t), .lat_b(lat_b_t), .lat_delta(lat_delta_t), .leak(leak_t),
        .leak_sticky(leak_sticky_t), .timeout(timeout_t), .run_count(run_count_t)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_main(input logic [3:0] pa, input logic [3:0] ca,
                            input logic [3:0] pb, input logic [3:0] cb,
                            output int n, output bit seen_done);
        mplier_a = pa; mcand_a = ca; mplier_b = pb; mcand_b = cb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (any_done) seen_done = 1'b1;
            if (result_valid) break;
        end
    endtask

    task automatic check_run(input string tag, input int n, input int n_exp,
                             input logic [31:0] pa, input logic [31:0] pb,
                             input logic [31:0] la, input logic [31:0] lb,
                             input logic [31:0] dl, input logic [31:0] lk,
                             input logic [31:0] st, input logic [31:0] rc);
        chk({tag, "_valid"},    32'(result_valid), 32'd1);
        chk({tag, "_cycles"},   32'(n),            32'(n_exp));
        chk({tag, "_prod_a"},   32'(product_a),    pa);
        chk({tag, "_prod_b"},   32'(product_b),    pb);
        chk({tag, "_lat_a"},    32'(lat_a),        la);
        chk({tag, "_lat_b"},    32'(lat_b),        lb);
        chk({tag, "_delta"},    32'(lat_delta),    dl);
        chk({tag, "_leak"},     32'(leak),         lk);
        chk({tag, "_sticky"},   32'(leak_sticky),  st);
        chk({tag, "_timeout"},  32'(timeout),      32'd0);
        chk({tag, "_runcount"}, 32'(run_count),    rc);
        tick();
        chk({tag, "_valid_pulse"}, 32'(result_valid), 32'd0);
        chk({tag, "_busy_low"},    32'(busy),         32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  rv_seen;

        // Reset state
        repeat (3) tick();
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_valid",  32'(result_valid), 32'd0);
        chk("rst_prod_a", 32'(product_a),   32'd0);
        chk("rst_lat_a",  32'(lat_a),       32'd0);
        chk("rst_runcnt", 32'(run_count),   32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // 1: mplier 1 vs 8, mcand 5
        run_main(4'b0001, 4'd5, 4'b1000, 4'd5, n, seen);
        chk("s1_any_done", 32'(seen), 32'd1);
        check_run("s1", n, 5, 32'd5, 32'd40, CT ? 32'd4 : 32'd1, 32'd4,
                  CT ? 32'd0 : 32'd3, CT ? 32'd0 : 32'd1, CT ? 32'd0 : 32'd1, 32'd1);

        // 2: equal latency, sticky must hold
        run_main(4'b1001, 4'd3, 4'b1111, 4'd3, n, seen);
        check_run("s2", n, 5, 32'd27, 32'd45, 32'd4, 32'd4, 32'd0, 32'd0,
                  CT ? 32'd0 : 32'd1, 32'd2);

        // 3: zero multipliers
        run_main(4'b0000, 4'd9, 4'b0000, 4'd7, n, seen);
        check_run("s3", n, CT ? 5 : 2, 32'd0, 32'd0, CT ? 32'd4 : 32'd1,
                  CT ? 32'd4 : 32'd1, 32'd0, 32'd0, CT ? 32'd0 : 32'd1, 32'd3);

        // clr_sticky pulse
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_sticky", 32'(leak_sticky), 32'd0);

        // 4: clr_sticky held through a leaky run: set wins
        clr_sticky = 1'b1;
        run_main(4'b0011, 4'd15, 4'b0100, 4'd15, n, seen);
        check_run("s4", n, CT ? 5 : 4, 32'd45, 32'd60, CT ? 32'd4 : 32'd2,
                  CT ? 32'd4 : 32'd3, CT ? 32'd0 : 32'd1, CT ? 32'd0 : 32'd1,
                  CT ? 32'd0 : 32'd1, 32'd4);
        clr_sticky = 1'b0;

        // 5: TIMEOUT=2 instance, start during BUSY ignored
        mplier_a = 4'b1000; mcand_a = 4'd3; mplier_b = 4'b0001; mcand_b = 4'd3;
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        chk("to_busy", 32'(busy_t), 32'd1);
        tick();
        mplier_a = 4'b0001;
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        chk("to_no_valid_yet", 32'(result_valid_t), 32'd0);
        tick();
        chk("to_valid",   32'(result_valid_t), 32'd1);
        chk("to_timeout", 32'(timeout_t),      32'd1);
        chk("to_lat_a",   32'(lat_a_t),        32'd2);
        chk("to_lat_b",   32'(lat_b_t),        CT ? 32'd2 : 32'd1);
        chk("to_delta",   32'(lat_delta_t),    CT ? 32'd0 : 32'd1);
        chk("to_leak",    32'(leak_t),         CT ? 32'd0 : 32'd1);
        chk("to_prod_a",  32'(product_a_t),    32'd0);
        chk("to_prod_b",  32'(product_b_t),    32'd3);
        chk("to_runcnt",  32'(run_count_t),    32'd1);
        tick();
        chk("to_busy_drop",  32'(busy_t),         32'd0);
        chk("to_valid_drop", 32'(result_valid_t), 32'd0);
        tick();
        chk("to_not_queued", 32'(busy_t),         32'd0);
        chk("to_timeout_hold", 32'(timeout_t),    32'd1);

        // 6: reset in second BUSY cycle
        mplier_a = 4'b0001; mcand_a = 4'd5; mplier_b = 4'b1000; mcand_b = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",   32'(busy),        32'd0);
        chk("mid_rst_prod_a", 32'(product_a),   32'd0);
        chk("mid_rst_lat_a",  32'(lat_a),       32'd0);
        chk("mid_rst_sticky", 32'(leak_sticky), 32'd0);
        chk("mid_rst_runcnt", 32'(run_count),   32'd0);
        chk("mid_rst_to_timeout", 32'(timeout_t), 32'd0);
        tick();
        rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (result_valid) rv_seen++;
        end
        chk("mid_rst_no_valid", 32'(rv_seen), 32'd0);
        chk("mid_rst_idle",     32'(busy),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_leak_monitor.md
Name: timing_leak_monitor

Overview:
- Parametrised successor to the two-lane multiplier timing tester.
- Runs two WIDTH-bit sequential shift-add multipliers side by side from one start pulse, one per secret operand.
- Measures each lane's latency in cycles, reports the latency difference, and raises a per-run leak flag and a sticky leak flag.
- Adds a timeout abort and an optional constant-time multiplier mode; sits in the side-channel test harness next to the multiplier.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.
- TIMEOUT, 16, maximum RUN cycles per lane before abort; must be >= 1.
- CNT_W, $clog2(TIMEOUT+1), latency counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  launch both lanes; accepted only in IDLE.
- mplier_a  input  WIDTH  lane A multiplier (secret).
- mcand_a  input  WIDTH  lane A multiplicand (public).
- mplier_b  input  WIDTH  lane B multiplier (secret).
- mcand_b  input  WIDTH  lane B multiplicand (public).
- clr_sticky  input  1  synchronous clear of leak_sticky.
- busy  output  1  high while lanes run.
- any_done  output  1  high in any cycle where either lane's done pulse is high.
- result_valid  output  1  one-cycle pulse; all result outputs valid from it until next start.
- product_a  output  2*WIDTH  lane A product.
- product_b  output  2*WIDTH  lane B product.
- lat_a  output  CNT_W  lane A RUN-cycle count.
- lat_b  output  CNT_W  lane B RUN-cycle count.
- lat_delta  output  CNT_W  |lat_a - lat_b|.
- leak  output  1  lat_delta != 0 for the last run.
- leak_sticky  output  1  OR of leak over all runs since reset/clear.
- timeout  output  1  last run aborted on timeout.
- run_count  output  16  completed runs, wraps at 0xFFFF -> 0.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; lane registers 0. Reset mid-run aborts immediately; no result_valid.
- Top FSM: IDLE -> BUSY -> REPORT -> IDLE.
  - IDLE: start=1 latches all four operands and clears lat/timeout; next state BUSY.
  - BUSY: busy=1. Each lane counter increments every cycle that lane is in RUN.
    - When both lanes have pulsed done, go to REPORT.
    - If either counter reaches TIMEOUT while its lane is not done: timeout=1, both lanes aborted to IDLE, go to REPORT.
  - REPORT: one cycle. result_valid=1, run_count+1, leak=(lat_delta!=0), leak_sticky|=leak. Next state IDLE.
- start in BUSY or REPORT is ignored, not queued.
- clr_sticky in the same cycle as a leaky REPORT: set wins, so leak_sticky=1.
- Lane (seq_mult), per cycle in RUN:
  - If mplier bit 0 is set, acc += mcand shifted left by iteration index.
  - Then mplier >>= 1 and index += 1.
  - Exit RUN after the cycle in which the shifted mplier becomes 0 (early exit), or after index reaches WIDTH.
  - Lane done pulses for one cycle after its final RUN cycle; product is held until the next start.
- Early-exit latency is max(1, msb_index+1) RUN cycles; mplier=0 gives 1 cycle with product 0.
- Products are exact: no truncation, and acc cannot overflow 2*WIDTH bits.
- lat_delta is computed combinationally from lat_a and lat_b and registered in REPORT.

Optional Feature:
- Macro: TLM_CONST_TIME_EN.
- Defined: each lane always runs exactly WIDTH RUN cycles with no early exit. lat_a = lat_b = WIDTH and leak is always 0 when TIMEOUT >= WIDTH.
- Undefined: early-exit behaviour as above; latency depends on the secret operand.

Decomposition:
- Shared package tlm_pkg holds:
  - state enum {IDLE, BUSY, REPORT};
  - lane state enum {L_IDLE, L_RUN, L_DONE};
  - the default WIDTH and TIMEOUT constants.
- One sub-module, seq_mult: clk, rst, start, abort, mplier, mcand, product, done, running. It is instantiated twice; the top level holds the counters, compare logic and FSM.

Test Plan:
- WIDTH=4, early mode: mplier_a=4'b0001, mplier_b=4'b1000, mcand=4'd5 both lanes -> lat_a=1, lat_b=4, lat_delta=3, product_a=5, product_b=40, leak=1, leak_sticky=1.
- Equal latency: mplier_a=4'b1001, mplier_b=4'b1111, mcand 3 -> lat 4/4, leak=0, products 27/45, leak_sticky unchanged.
- mplier_a=0, mplier_b=0 -> lat 1/1, products 0, leak=0; run_count increments by 1.
- TIMEOUT=2: mplier_a=4'b1000 -> timeout=1, result_valid pulse, busy drops; start pulsed during BUSY is ignored.
- TLM_CONST_TIME_EN defined, repeat the first scenario -> lat 4/4, leak=0, products 5/40.
- Assert rst in the 2nd BUSY cycle -> all outputs 0 the same cycle, no result_valid. clr_sticky while leak_sticky=1 -> 0 next cycle.
